pemstat_rdctl: RTL and testbench
================================

PEMSTAT_RDCTL -- requirements
Module: pemstat_rdctl

Interface
REQ-001 Parameter NCNT, default 16, number of statistics counters in the bank (2..16).
REQ-002 Parameter DLY, default 1, non-blocking assignment delay in ns, simulation only.
REQ-003 clk  in  1  single clock for all state.
REQ-004 reset  in  1  asynchronous, active-high reset.
REQ-005 rd_req  in  1  host read request pulse.
REQ-006 rd_addr  in  4  counter index to read.
REQ-007 rd_clr  in  1  clear-on-read enable, sampled with rd_req.
REQ-008 wr_req  in  1  host write (preload) request pulse.
REQ-009 wr_addr  in  4  counter index to preload.
REQ-010 wr_data  in  31  preload value.
REQ-011 cnt_rdata  in  31  bank read-mux output for cnt_addr, valid one cycle after cnt_addr changes.
REQ-012 cnt_carry  in  NCNT  per-counter carry flags from the bank.
REQ-013 carry_mask  in  NCNT  1 = suppress the interrupt contribution of that counter.
REQ-014 cnt_addr  out  4  selected counter.
REQ-015 cnt_load  out  1  one-cycle load strobe to the selected counter.
REQ-016 cnt_wdata  out  31  load value.
REQ-017 cnt_clr  out  1  one-cycle clear strobe to the selected counter.
REQ-018 cnt_carry_clr  out  1  one-cycle carry-flag clear strobe to the selected counter.
REQ-019 rd_data  out  31  captured counter value.
REQ-020 rd_ack  out  1  one-cycle read-complete pulse.
REQ-021 wr_ack  out  1  one-cycle write-complete pulse.
REQ-022 busy  out  1  high in every state except IDLE.
REQ-023 carry_stat  out  NCNT  sticky carry status.
REQ-024 carry_int  out  1  OR of carry_stat & ~carry_mask.

Function
REQ-025 The FSM SHALL have states IDLE, RADDR, RCAPT, WLOAD, ACK; all outputs are registered.
REQ-026 Requests SHALL be sampled only in IDLE; requests arriving while busy are dropped, not queued.
REQ-027 If wr_req and rd_req are both high in IDLE, the write SHALL win and the read is dropped.
REQ-028 Read: rd_req at edge N -> RADDR at N+1 (cnt_addr=rd_addr) -> RCAPT at N+2 -> ACK at N+3 with rd_ack=1 and rd_data=cnt_rdata sampled at the end of RCAPT -> IDLE at N+4.
REQ-029 In RCAPT, when latched rd_clr=1, the FSM SHALL assert cnt_clr and cnt_carry_clr for exactly one cycle, coincident with the data capture, so that no increment is lost or double-counted.
REQ-030 Write: wr_req at edge N -> WLOAD at N+1 with cnt_load=1, cnt_addr=wr_addr, cnt_wdata=wr_data -> ACK at N+2 with wr_ack=1 -> IDLE.
REQ-031 A read or write with addr >= NCNT SHALL complete normally, with rd_data=0 and no cnt_load/cnt_clr strobes.
REQ-032 carry_stat[i] SHALL set on a rising edge of cnt_carry[i] and clear on a clear-on-read of counter i; if set and clear coincide, set wins.
REQ-033 cnt_carry_clr SHALL NOT be asserted for reads with rd_clr=0; carry_stat is then unchanged.

Reset
REQ-034 Reset SHALL force the FSM to IDLE and drive every output to 0 (rd_data, cnt_wdata and cnt_addr all zero, carry_stat=0, carry_int=0).
REQ-035 Reset mid-transaction SHALL abort it with no ack and no strobe in the cycle after reset deasserts.

Configuration
REQ-036 Macro PEMSTAT_RDCTL_CARRY_INT_EN: when defined, carry_stat and carry_int behave per REQ-023/024/032; when undefined, both are tied to 0, edge-detect registers are removed, and cnt_carry and carry_mask are ignored.

Verification
REQ-037 Preload counter 3 (value 0x1F4), then read with rd_clr=0 -> wr_ack at N+2, rd_ack at N+3 of the read with rd_data=0x1F4, no cnt_clr.
REQ-038 Counter 5 = 0x0AB, read with rd_clr=1 while the bank increments by 2 in the RCAPT cycle -> rd_data=0x0AB, one cnt_clr pulse, next read returns 0x002.
REQ-039 rd_req and wr_req in the same cycle -> only wr_ack; no rd_ack; second rd_req while busy dropped.
REQ-040 cnt_carry[7] rises with carry_mask=0 -> carry_stat[7]=1, carry_int=1; mask bit 7 -> carry_int=0; clear-on-read of counter 7 -> carry_stat[7]=0.
REQ-041 Reset asserted in RCAPT -> outputs 0 and FSM in IDLE, no rd_ack; read of addr 15 with NCNT=8 -> rd_data=0, rd_ack at N+3.

Source files
------------

// File: rtl/pemstat_rdctl_if.sv
// Host/bank signal bundle for the statistics-counter read/preload controller.
// master = host plus counter bank side, slave = pemstat_rdctl.
interface pemstat_rdctl_if #(
  parameter int NCNT = 16
);
  logic            rd_req;
  logic [3:0]      rd_addr;
  logic            rd_clr;
  logic            wr_req;
  logic [3:0]      wr_addr;
  logic [30:0]     wr_data;
  logic [30:0]     cnt_rdata;
  logic [NCNT-1:0] cnt_carry;
  logic [NCNT-1:0] carry_mask;
  logic [3:0]      cnt_addr;
  logic            cnt_load;
  logic [30:0]     cnt_wdata;
  logic            cnt_clr;
  logic            cnt_carry_clr;
  logic [30:0]     rd_data;
  logic            rd_ack;
  logic            wr_ack;
  logic            busy;
  logic [NCNT-1:0] carry_stat;
  logic            carry_int;

  modport master (
    output rd_req, rd_addr, rd_clr, wr_req, wr_addr, wr_data,
           cnt_rdata, cnt_carry, carry_mask,
    input  cnt_addr, cnt_load, cnt_wdata, cnt_clr, cnt_carry_clr,
           rd_data, rd_ack, wr_ack, busy, carry_stat, carry_int
  );

  modport slave (
    input  rd_req, rd_addr, rd_clr, wr_req, wr_addr, wr_data,
           cnt_rdata, cnt_carry, carry_mask,
    output cnt_addr, cnt_load, cnt_wdata, cnt_clr, cnt_carry_clr,
           rd_data, rd_ack, wr_ack, busy, carry_stat, carry_int
  );
endinterface

// File: rtl/pemstat_rdctl.sv
// Read / clear-on-read / preload controller for a bank of statistics counters.
// Optional sticky carry status and interrupt: define PEMSTAT_RDCTL_CARRY_INT_EN.
module pemstat_rdctl #(
  parameter int NCNT = 16,
  parameter int DLY  = 1
) (
  input  logic           clk,
  input  logic           reset,
  pemstat_rdctl_if.slave bus
);
  // DLY only mattered for delayed assignments in simulation models; nothing here uses it.
  localparam int unused_dly = DLY;

  typedef enum logic [2:0] {IDLE, RADDR, RCAPT, WLOAD, ACK} state_t;

  state_t      state_reg, state_next;
  logic [3:0]  cnt_addr_reg, cnt_addr_next;
  logic [30:0] cnt_wdata_reg, cnt_wdata_next;
  logic [30:0] rd_data_reg, rd_data_next;
  logic        cnt_load_reg, cnt_load_next;
  logic        clr_strobe_reg, clr_strobe_next;
  logic        rd_clr_reg, rd_clr_next;
  logic        rd_ack_reg, rd_ack_next;
  logic        wr_ack_reg, wr_ack_next;
  logic        busy_reg, busy_next;
  logic        addr_ok, wr_addr_ok;

  assign addr_ok    = ({1'b0, cnt_addr_reg} < 5'(NCNT));
  assign wr_addr_ok = ({1'b0, bus.wr_addr} < 5'(NCNT));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // Write has priority over a simultaneous read; anything arriving outside IDLE is ignored.
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE: begin
        if (bus.wr_req) begin
          state_next = WLOAD;
        end else if (bus.rd_req) begin
          state_next = RADDR;
        end
      end
      RADDR:   state_next = RCAPT;
      RCAPT:   state_next = ACK;
      WLOAD:   state_next = ACK;
      ACK:     state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    cnt_addr_next   = cnt_addr_reg;
    cnt_wdata_next  = cnt_wdata_reg;
    rd_data_next    = rd_data_reg;
    rd_clr_next     = rd_clr_reg;
    cnt_load_next   = 1'b0;
    clr_strobe_next = 1'b0;
    rd_ack_next     = 1'b0;
    wr_ack_next     = 1'b0;
    busy_next       = (state_next != IDLE);
    case (state_reg)
      IDLE: begin
        if (bus.wr_req) begin
          cnt_addr_next  = bus.wr_addr;
          cnt_wdata_next = bus.wr_data;
          cnt_load_next  = wr_addr_ok;
        end else if (bus.rd_req) begin
          cnt_addr_next = bus.rd_addr;
          rd_clr_next   = bus.rd_clr;
        end
      end
      // Clear strobe lands in RCAPT so the bank clears on the same edge that captures the data.
      RADDR: clr_strobe_next = rd_clr_reg & addr_ok;
      RCAPT: begin
        rd_data_next = addr_ok ? bus.cnt_rdata : 31'd0;
        rd_ack_next  = 1'b1;
      end
      WLOAD: wr_ack_next = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_addr_reg   <= '0;
      cnt_wdata_reg  <= '0;
      rd_data_reg    <= '0;
      rd_clr_reg     <= 1'b0;
      cnt_load_reg   <= 1'b0;
      clr_strobe_reg <= 1'b0;
      rd_ack_reg     <= 1'b0;
      wr_ack_reg     <= 1'b0;
      busy_reg       <= 1'b0;
    end else begin
      cnt_addr_reg   <= cnt_addr_next;
      cnt_wdata_reg  <= cnt_wdata_next;
      rd_data_reg    <= rd_data_next;
      rd_clr_reg     <= rd_clr_next;
      cnt_load_reg   <= cnt_load_next;
      clr_strobe_reg <= clr_strobe_next;
      rd_ack_reg     <= rd_ack_next;
      wr_ack_reg     <= wr_ack_next;
      busy_reg       <= busy_next;
    end
  end

  assign bus.cnt_addr      = cnt_addr_reg;
  assign bus.cnt_wdata     = cnt_wdata_reg;
  assign bus.cnt_load      = cnt_load_reg;
  assign bus.cnt_clr       = clr_strobe_reg;
  assign bus.cnt_carry_clr = clr_strobe_reg;
  assign bus.rd_data       = rd_data_reg;
  assign bus.rd_ack        = rd_ack_reg;
  assign bus.wr_ack        = wr_ack_reg;
  assign bus.busy          = busy_reg;

`ifdef PEMSTAT_RDCTL_CARRY_INT_EN
  logic [NCNT-1:0] carry_prev_reg, carry_stat_reg, carry_stat_next, carry_clr_vec;
  logic            carry_int_reg;

  // Rising carry edge sets; clear-on-read clears; a coincident rise keeps the bit set.
  for (genvar gi = 0; gi < NCNT; gi++) begin : g_carry
    assign carry_clr_vec[gi]   = clr_strobe_reg && (cnt_addr_reg == 4'(gi));
    assign carry_stat_next[gi] = (carry_stat_reg[gi] & ~carry_clr_vec[gi])
                               | (bus.cnt_carry[gi] & ~carry_prev_reg[gi]);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      carry_prev_reg <= '0;
      carry_stat_reg <= '0;
      carry_int_reg  <= 1'b0;
    end else begin
      carry_prev_reg <= bus.cnt_carry;
      carry_stat_reg <= carry_stat_next;
      carry_int_reg  <= |(carry_stat_next & ~bus.carry_mask);
    end
  end

  assign bus.carry_stat = carry_stat_reg;
  assign bus.carry_int  = carry_int_reg;
`else
  logic unused_carry;
  assign unused_carry   = ^{bus.cnt_carry, bus.carry_mask};
  assign bus.carry_stat = '0;
  assign bus.carry_int  = 1'b0;
`endif
endmodule

// File: tb/tb_pemstat_rdctl.sv
// Randomized bench for pemstat_rdctl: bench-owned counter bank plus a transaction-level model
// of expected counter contents, acks and strobes.
module tb_pemstat_rdctl;
  localparam int NCNT = 8;

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic bank_init = 1'b1;
  logic inc_en = 1'b0;
  logic [3:0] inc_addr = '0;
  logic [30:0] inc_val = '0;
  int tests = 0;
  int fails = 0;

  logic [30:0] bank [16];
  logic [30:0] bank_next [16];
  logic [30:0] model [16];

  pemstat_rdctl_if #(.NCNT(NCNT)) bus ();

  pemstat_rdctl #(.NCNT(NCNT), .DLY(1)) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus.slave)
  );

  always #5 clk = ~clk;

  // Counter bank: clear coincident with an increment keeps the increment.
  always_comb begin
    for (int i = 0; i < 16; i++) begin
      bank_next[i] = bank[i];
      if (inc_en && inc_addr == 4'(i)) bank_next[i] = bank[i] + inc_val;
      if (bus.cnt_clr && bus.cnt_addr == 4'(i))
        bank_next[i] = (inc_en && inc_addr == 4'(i)) ? inc_val : 31'd0;
      if (bus.cnt_load && bus.cnt_addr == 4'(i)) bank_next[i] = bus.cnt_wdata;
    end
  end

  always @(posedge clk) begin
    for (int i = 0; i < 16; i++) bank[i] <= bank_init ? 31'd0 : bank_next[i];
  end

  assign bus.cnt_rdata = bank[bus.cnt_addr];

  task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, required 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [127:0] all_outputs();
    return {bus.cnt_addr, bus.cnt_load, bus.cnt_wdata, bus.cnt_clr, bus.cnt_carry_clr,
            bus.rd_data, bus.rd_ack, bus.wr_ack, bus.busy, bus.carry_stat, bus.carry_int};
  endfunction

  // Called at a negedge while idle; returns at the negedge of the first idle cycle afterwards.
  task automatic run_write(input logic [3:0] a, input logic [30:0] d);
    int ack_at = 0, ack_n = 0, load_n = 0, busy_bad = 0, load_bad = 0;
    bit valid;
    valid = (a < NCNT);
    bus.wr_req = 1'b1; bus.wr_addr = a; bus.wr_data = d;
    for (int j = 1; j <= 3; j++) begin
      @(negedge clk);
      if (j == 1) bus.wr_req = 1'b0;
      if (bus.wr_ack) begin ack_n++; if (ack_at == 0) ack_at = j; end
      if (bus.cnt_load) begin
        load_n++;
        if (j != 1 || bus.cnt_addr != a || bus.cnt_wdata != d) load_bad++;
      end
      if (bus.busy != (j <= 2)) busy_bad++;
      if (bus.rd_ack) ack_n += 10;
    end
    check_eq("wr_ack_cycle", 128'(ack_at), 128'd2);
    check_eq("wr_ack_count", 128'(ack_n), 128'd1);
    check_eq("wr_load_count", 128'(load_n), valid ? 128'd1 : 128'd0);
    check_eq("wr_load_fields", 128'(load_bad), 128'd0);
    check_eq("wr_busy", 128'(busy_bad), 128'd0);
    if (valid) model[a] = d;
    check_eq("wr_bank", 128'(bank[a]), 128'(model[a]));
    $display("[TB] write addr=%0d data=0x%0h ack_cycle=%0d", a, d, ack_at);
  endtask

  // iv is added to counter a by the bank on the edge that ends the capture cycle.
  task automatic run_read(input logic [3:0] a, input logic c, input logic [30:0] iv);
    int ack_at = 0, ack_n = 0, clr_n = 0, cclr_n = 0, load_n = 0, busy_bad = 0;
    logic [30:0] exp_d, got_d;
    bit valid;
    valid = (a < NCNT);
    exp_d = valid ? model[a] : 31'd0;
    got_d = '1;
    bus.rd_req = 1'b1; bus.rd_addr = a; bus.rd_clr = c;
    for (int j = 1; j <= 4; j++) begin
      @(negedge clk);
      if (j == 1) bus.rd_req = 1'b0;
      if (j == 2) begin inc_en = 1'b1; inc_addr = a; inc_val = iv; end
      if (j == 3) inc_en = 1'b0;
      if (bus.rd_ack) begin ack_n++; if (ack_at == 0) ack_at = j; got_d = bus.rd_data; end
      if (bus.wr_ack) ack_n += 10;
      if (bus.cnt_clr) clr_n++;
      if (bus.cnt_carry_clr) cclr_n++;
      if (bus.cnt_load) load_n++;
      if (bus.busy != (j <= 3)) busy_bad++;
    end
    check_eq("rd_ack_cycle", 128'(ack_at), 128'd3);
    check_eq("rd_ack_count", 128'(ack_n), 128'd1);
    check_eq("rd_data", 128'(got_d), 128'(exp_d));
    check_eq("rd_clr_count", 128'(clr_n), (c && valid) ? 128'd1 : 128'd0);
    check_eq("rd_carry_clr_count", 128'(cclr_n), (c && valid) ? 128'd1 : 128'd0);
    check_eq("rd_no_load", 128'(load_n), 128'd0);
    check_eq("rd_busy", 128'(busy_bad), 128'd0);
    if (c && valid) model[a] = iv;
    else model[a] = model[a] + iv;
    check_eq("rd_bank", 128'(bank[a]), 128'(model[a]));
    $display("[TB] read addr=%0d clr=%0d inc=%0d data=0x%0h ack_cycle=%0d", a, c, iv, got_d, ack_at);
  endtask

  task automatic bump(input logic [3:0] a, input logic [30:0] v);
    inc_en = 1'b1; inc_addr = a; inc_val = v;
    @(negedge clk);
    inc_en = 1'b0;
    model[a] = model[a] + v;
  endtask

  initial begin
    int rd_n, wr_n;
    bus.rd_req = 0; bus.rd_addr = 0; bus.rd_clr = 0;
    bus.wr_req = 0; bus.wr_addr = 0; bus.wr_data = 0;
    bus.cnt_carry = '0; bus.carry_mask = '0;
    for (int i = 0; i < 16; i++) model[i] = 31'd0;
    #1 reset = 1'b1;
    repeat (3) @(negedge clk);
    check_eq("reset_outputs", all_outputs(), 128'd0);
    bank_init = 1'b0;
    reset = 1'b0;
    @(negedge clk);
    check_eq("idle_after_reset", all_outputs(), 128'd0);

    // Preload then plain read.
    run_write(4'd3, 31'h1F4);
    run_read(4'd3, 1'b0, 31'd0);

    // Clear-on-read while the bank increments in the capture cycle.
    run_write(4'd5, 31'h0AB);
    run_read(4'd5, 1'b1, 31'd2);
    run_read(4'd5, 1'b0, 31'd0);

    // Simultaneous read/write: write wins, a read while busy is dropped.
    rd_n = 0; wr_n = 0;
    bus.rd_req = 1; bus.rd_addr = 4'd2; bus.rd_clr = 1'b0;
    bus.wr_req = 1; bus.wr_addr = 4'd2; bus.wr_data = 31'h55;
    for (int j = 1; j <= 6; j++) begin
      @(negedge clk);
      if (j == 1) begin bus.wr_req = 0; bus.rd_req = 1; end
      if (j == 2) bus.rd_req = 0;
      if (bus.rd_ack) rd_n++;
      if (bus.wr_ack) wr_n++;
    end
    model[2] = 31'h55;
    check_eq("collide_wr_ack", 128'(wr_n), 128'd1);
    check_eq("collide_rd_ack", 128'(rd_n), 128'd0);
    check_eq("collide_bank", 128'(bank[2]), 128'(model[2]));
    $display("[TB] collide rd+wr addr=2 wr_acks=%0d rd_acks=%0d", wr_n, rd_n);

    // Carry status.
    bus.cnt_carry[7] = 1'b1;
    @(negedge clk);
`ifdef PEMSTAT_RDCTL_CARRY_INT_EN
    check_eq("carry_stat_set", 128'(bus.carry_stat), 128'h80);
    check_eq("carry_int_set", 128'(bus.carry_int), 128'd1);
    bus.carry_mask[7] = 1'b1;
    @(negedge clk);
    check_eq("carry_int_masked", 128'(bus.carry_int), 128'd0);
    bus.cnt_carry[7] = 1'b0;
    run_read(4'd7, 1'b0, 31'd0);
    check_eq("carry_keep_noclr", 128'(bus.carry_stat), 128'h80);
    run_read(4'd7, 1'b1, 31'd0);
    check_eq("carry_cleared", 128'(bus.carry_stat), 128'h00);
    bus.carry_mask = '0;
    @(negedge clk);
    check_eq("carry_int_after_clr", 128'(bus.carry_int), 128'd0);
`else
    check_eq("carry_stat_off", 128'(bus.carry_stat), 128'd0);
    check_eq("carry_int_off", 128'(bus.carry_int), 128'd0);
    bus.cnt_carry[7] = 1'b0;
`endif
    $display("[TB] carry test stat=0x%0h int=%0d", bus.carry_stat, bus.carry_int);

    // Reset during the capture cycle aborts the read without clearing.
    bus.rd_req = 1; bus.rd_addr = 4'd5; bus.rd_clr = 1'b1;
    @(negedge clk);
    bus.rd_req = 0;
    @(negedge clk);
    check_eq("abort_clr_pending", 128'(bus.cnt_clr), 128'd1);
    #2 reset = 1'b1;
    #1 check_eq("abort_outputs", all_outputs(), 128'd0);
    @(negedge clk);
    reset = 1'b0;
    rd_n = 0;
    for (int j = 1; j <= 4; j++) begin
      @(negedge clk);
      if (bus.rd_ack || bus.cnt_clr || bus.busy) rd_n++;
    end
    check_eq("abort_quiet", 128'(rd_n), 128'd0);
    check_eq("abort_bank", 128'(bank[5]), 128'(model[5]));
    $display("[TB] reset abort quiet_violations=%0d", rd_n);

    // Out-of-range address.
    run_read(4'd15, 1'b1, 31'd0);
    run_write(4'd12, 31'h123);

    for (int k = 0; k < 40; k++) begin
      logic [3:0] a;
      a = 4'($urandom_range(0, 15));
      case ($urandom_range(0, 2))
        0: run_write(a, 31'($urandom));
        1: run_read(a, 1'($urandom), 31'($urandom_range(0, 7)));
        default: begin
          bump(a, 31'($urandom_range(1, 100)));
          run_read(a, 1'($urandom), 31'($urandom_range(0, 7)));
        end
      endcase
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
